mem_lsu: RTL

Memory-access stage of the 5-stage pipeline, between the EX/MEM register and the WB stage. Turns the EX result and store data into a byte-enabled request on a ready-handshake data-memory port, waits for completion with a bounded timeout, and registers the MEM/WB payload in exactly the `WB_CTRL`/`WB_DATA` packing WB consumes. Load data goes out as the raw 32-bit word; WB does the byte/half lane extraction and sign extension.

---
 rtl/mem_pkg.sv | 37 +++
 rtl/mem_lsu_if.sv | 20 ++
 rtl/dm_lane_gen.sv | 33 +++
 rtl/mem_lsu.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared widths, control-bit positions, FSM states and byte-enable constants
// for the memory-access stage.
package mem_pkg;

  localparam int CTRL_W = 7;
  localparam int WBC_W  = 5;
  localparam int WBD_W  = 69;
  localparam int MD_W   = 69;
  localparam int FWD_W  = 38;

  // MEM_CTRL = {memRead, memWrite, regWrite, memToReg, isDMByte, isDMHalf, isLOADS}
  localparam int C_MEMREAD  = 6;
  localparam int C_MEMWRITE = 5;
  localparam int C_REGWRITE = 4;
  localparam int C_MEMTOREG = 3;
  localparam int C_ISBYTE   = 2;
  localparam int C_ISHALF   = 1;
  localparam int C_ISLOADS  = 0;

  typedef enum logic {IDLE, WAIT} state_e;

  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Byte wins over half if both flags are set.
  function automatic size_e ctrl_size(input logic [CTRL_W-1:0] ctrl);
    if (ctrl[C_ISBYTE])      return SZ_BYTE;
    else if (ctrl[C_ISHALF]) return SZ_HALF;
    else                     return SZ_WORD;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Ready-handshake data-memory port between the MEM stage (master) and data memory.
interface mem_lsu_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_rdata, dm_ready
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_rdata, dm_ready
  );
endinterface

// File: rtl/dm_lane_gen.sv
// Byte-lane enables, replicated write data and alignment check for one access.
module dm_lane_gen
  import mem_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);

  always_comb begin
    be_o       = BE_WORD;
    wdata_o    = store_data_i;
    misalign_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        be_o    = BE_BYTE0 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      SZ_HALF: begin
        be_o       = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_o    = {2{store_data_i[15:0]}};
        misalign_o = addr_lo_i[0];
      end
      default: begin
        misalign_o = |addr_lo_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage: issues the data-memory request, waits with a bounded timeout,
// and registers the MEM/WB payload.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] MEM_CTRL,
  input  logic [MD_W-1:0]   MEM_DATA,
  input  logic              flush,
  output logic              o_stall,
  mem_lsu_if.master         dm,
  output logic [WBC_W-1:0]  WB_CTRL,
  output logic [WBD_W-1:0]  WB_DATA,
  output logic [FWD_W-1:0]  o_MEM_FWD,
  output logic              o_misalign,
  output logic              o_bus_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [4:0]  rw_in;
  logic [31:0] ex_in;
  logic [31:0] sd_in;
  assign rw_in = MEM_DATA[68:64];
  assign ex_in = MEM_DATA[63:32];
  assign sd_in = MEM_DATA[31:0];

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [4:0]  lat_ctrl_q;
  logic [4:0]  lat_rw_q;
  logic [31:0] lat_ex_q;
  logic        lat_rd_q;
  logic        lat_we_q;
  logic [3:0]  lat_be_q;
  logic [31:0] lat_wdata_q;
  logic [WBC_W-1:0] wb_ctrl_q;
  logic [WBD_W-1:0] wb_data_q;
  logic        mis_q;
  logic        berr_q;

  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic        mis_c;

  dm_lane_gen u_lane (
    .size_i       (ctrl_size(MEM_CTRL)),
    .addr_lo_i    (ex_in[1:0]),
    .store_data_i (sd_in),
    .be_o         (be_c),
    .wdata_o      (wdata_c),
    .misalign_o   (mis_c)
  );

  logic memop, aligned_op, timeout, req;
  assign memop      = in_valid && (MEM_CTRL[C_MEMREAD] || MEM_CTRL[C_MEMWRITE]);
  assign aligned_op = memop && !mis_c;
  assign timeout    = (state_q == WAIT) && !dm.dm_ready && (cnt_q == CNT_LAST);
  assign req        = !rst && !flush && ((state_q == WAIT) || aligned_op);

  assign o_stall = !rst && !flush &&
                   (((state_q == IDLE) && aligned_op && !dm.dm_ready) ||
                    ((state_q == WAIT) && !dm.dm_ready && !timeout));

  // While waiting, the bus is driven from the latched copy so it cannot move.
  always_comb begin
    dm.dm_req   = req;
    dm.dm_we    = 1'b0;
    dm.dm_addr  = 32'h0;
    dm.dm_be    = BE_NONE;
    dm.dm_wdata = 32'h0;
    if (req) begin
      if (state_q == WAIT) begin
        dm.dm_we    = lat_we_q;
        dm.dm_addr  = {lat_ex_q[31:2], 2'b00};
        dm.dm_be    = lat_be_q;
        dm.dm_wdata = lat_wdata_q;
      end else begin
        dm.dm_we    = MEM_CTRL[C_MEMWRITE];
        dm.dm_addr  = {ex_in[31:2], 2'b00};
        dm.dm_be    = be_c;
        dm.dm_wdata = wdata_c;
      end
    end
  end

  logic [WBC_W-1:0] wb_ctrl_d;
  logic [WBD_W-1:0] wb_data_d;
  always_comb begin
    if (state_q == WAIT) begin
      wb_ctrl_d = lat_ctrl_q;
      wb_data_d = {lat_rw_q, lat_ex_q, lat_rd_q ? dm.dm_rdata : 32'h0};
    end else begin
      wb_ctrl_d = MEM_CTRL[4:0];
      wb_data_d = {rw_in, ex_in, MEM_CTRL[C_MEMREAD] ? dm.dm_rdata : 32'h0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'h0;
      lat_ctrl_q  <= 5'h0;
      lat_rw_q    <= 5'h0;
      lat_ex_q    <= 32'h0;
      lat_rd_q    <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_be_q    <= BE_NONE;
      lat_wdata_q <= 32'h0;
      wb_ctrl_q   <= '0;
      wb_data_q   <= '0;
      mis_q       <= 1'b0;
      berr_q      <= 1'b0;
    end else begin
      wb_ctrl_q <= '0;
      wb_data_q <= '0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
        cnt_q   <= 8'h0;
      end else begin
        case (state_q)
          IDLE: begin
            if (in_valid) begin
              if (!memop || (!mis_c && dm.dm_ready)) begin
                wb_ctrl_q <= wb_ctrl_d;
                wb_data_q <= wb_data_d;
              end else if (mis_c) begin
                mis_q <= 1'b1;
              end else begin
                state_q     <= WAIT;
                cnt_q       <= 8'h0;
                lat_ctrl_q  <= MEM_CTRL[4:0];
                lat_rw_q    <= rw_in;
                lat_ex_q    <= ex_in;
                lat_rd_q    <= MEM_CTRL[C_MEMREAD];
                lat_we_q    <= MEM_CTRL[C_MEMWRITE];
                lat_be_q    <= be_c;
                lat_wdata_q <= wdata_c;
              end
            end
          end
          WAIT: begin
            if (dm.dm_ready) begin
              state_q   <= IDLE;
              wb_ctrl_q <= wb_ctrl_d;
              wb_data_q <= wb_data_d;
            end else if (timeout) begin
              state_q <= IDLE;
              cnt_q   <= 8'h0;
              berr_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 8'h1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign WB_CTRL    = wb_ctrl_q;
  assign WB_DATA    = wb_data_q;
  assign o_misalign = mis_q;
  assign o_bus_err  = berr_q;
  assign o_MEM_FWD  = rst ? '0 : {MEM_CTRL[C_REGWRITE] & in_valid, ex_in, rw_in};

endmodule
